// File: rtl/pc_core_ctrl_seq_if.sv
// pc_core_ctrl_seq_if: host/channel handshake bundle for pc_core_ctrl_seq.
// The watchdog signals exist only when PC_CTRL_WATCHDOG_EN is defined.
interface pc_core_ctrl_seq_if #(
  parameter int C_NUM_CH    = 2,
  parameter int C_CNT_WIDTH = 32
);
  logic                   ap_start;
  logic                   ap_continue;
  logic                   ap_idle;
  logic                   ap_done;
  logic                   ap_ready;
  logic [C_NUM_CH-1:0]    ch_enable;
  logic [C_NUM_CH-1:0]    ch_start;
  logic [C_NUM_CH-1:0]    ch_done;
  logic [C_NUM_CH-1:0]    run_mask;
  logic [C_CNT_WIDTH-1:0] run_cycles;
`ifdef PC_CTRL_WATCHDOG_EN
  logic [C_CNT_WIDTH-1:0] wdog_limit;
  logic                   ap_timeout;
  logic [C_NUM_CH-1:0]    timeout_mask;
  modport master (
    output ap_start, ap_continue, ch_enable, ch_done, wdog_limit,
    input  ap_idle, ap_done, ap_ready, ch_start, run_mask, run_cycles, ap_timeout, timeout_mask
  );
  modport slave (
    input  ap_start, ap_continue, ch_enable, ch_done, wdog_limit,
    output ap_idle, ap_done, ap_ready, ch_start, run_mask, run_cycles, ap_timeout, timeout_mask
  );
`else
  modport master (
    output ap_start, ap_continue, ch_enable, ch_done,
    input  ap_idle, ap_done, ap_ready, ch_start, run_mask, run_cycles
  );
  modport slave (
    input  ap_start, ap_continue, ch_enable, ch_done,
    output ap_idle, ap_done, ap_ready, ch_start, run_mask, run_cycles
  );
`endif
endinterface

// File: rtl/pc_core_ctrl_seq.sv
// pc_core_ctrl_seq: N-channel ap_ctrl_hs/ap_ctrl_chain start/done sequencer with run-cycle counter.
// Define PC_CTRL_WATCHDOG_EN to add the wdog_limit/ap_timeout/timeout_mask watchdog.
module pc_core_ctrl_seq #(
  parameter int C_NUM_CH     = 2,
  parameter int C_CHAIN_MODE = 0,
  parameter int C_CNT_WIDTH  = 32
) (
  input logic               ap_clk,
  input logic               areset,
  pc_core_ctrl_seq_if.slave bus
);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t                 state;
  logic                   start_r, idle_q, done_q, pulse, all_done;
  logic [C_NUM_CH-1:0]    done_r, done_nx, mask_q, start_q;
  logic [C_CNT_WIDTH-1:0] counter, cnt_inc, cycles_q;
  assign pulse    = bus.ap_start & ~start_r;
  assign done_nx  = done_r | (bus.ch_done & mask_q);
  assign all_done = done_nx == mask_q;
  assign cnt_inc  = &counter ? counter : counter + 1'b1;
  assign bus.ap_idle    = idle_q;
  assign bus.ap_done    = done_q;
  assign bus.ap_ready   = done_q;
  assign bus.ch_start   = start_q;
  assign bus.run_mask   = mask_q;
  assign bus.run_cycles = cycles_q;
`ifdef PC_CTRL_WATCHDOG_EN
  logic                to_q, wdog_hit;
  logic [C_NUM_CH-1:0] tmask_q;
  assign wdog_hit         = bus.wdog_limit != '0 && cnt_inc == bus.wdog_limit;
  assign bus.ap_timeout   = to_q;
  assign bus.timeout_mask = tmask_q;
`endif
  always_ff @(posedge ap_clk or posedge areset) begin
    if (areset) begin
      state    <= IDLE;
      start_r  <= 1'b0;
      idle_q   <= 1'b1;
      done_q   <= 1'b0;
      done_r   <= '0;
      mask_q   <= '0;
      start_q  <= '0;
      counter  <= '0;
      cycles_q <= '0;
`ifdef PC_CTRL_WATCHDOG_EN
      to_q     <= 1'b0;
      tmask_q  <= '0;
`endif
    end else begin
      start_r <= bus.ap_start;
      start_q <= '0;
      case (state)
        IDLE: if (pulse) begin
          state   <= RUN;
          idle_q  <= 1'b0;
          mask_q  <= bus.ch_enable;
          start_q <= bus.ch_enable;
          done_r  <= '0;
          counter <= '0;
`ifdef PC_CTRL_WATCHDOG_EN
          to_q    <= 1'b0;
          tmask_q <= '0;
`endif
        end
        RUN: begin
          counter <= cnt_inc;
          done_r  <= done_nx;
          // completion has priority over a watchdog hit in the same cycle
          if (all_done) begin
            state    <= DONE;
            done_q   <= 1'b1;
            cycles_q <= cnt_inc;
          end
`ifdef PC_CTRL_WATCHDOG_EN
          else if (wdog_hit) begin
            state    <= DONE;
            done_q   <= 1'b1;
            cycles_q <= bus.wdog_limit;
            to_q     <= 1'b1;
            tmask_q  <= mask_q & ~done_nx;
          end
`endif
        end
        default: if (C_CHAIN_MODE == 0 || bus.ap_continue) begin
          state  <= IDLE;
          done_q <= 1'b0;
          idle_q <= 1'b1;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_pc_core_ctrl_seq.sv
// tb_pc_core_ctrl_seq: random runs on hs, chain and 4-bit-counter instances against a per-run model.
// Honours PC_CTRL_WATCHDOG_EN for the watchdog checks.
module tb_pc_core_ctrl_seq;
  localparam int N = 4;
  logic         ap_clk = 1'b0, areset = 1'b1, ap_start = 1'b0, ap_continue = 1'b0;
  logic [N-1:0] ch_enable = '0, ch_done = '0;
  logic [N-1:0] e_mask = '0;
  logic [31:0]  e_cyc = '0;
  int           dly [N];
  int           vectors = 0, miscompares = 0;
`ifdef PC_CTRL_WATCHDOG_EN
  logic [31:0]  wdog_limit = '0;
  logic         e_to = 1'b0;
  logic [N-1:0] e_tm = '0;
`endif
  always #5 ap_clk = ~ap_clk;
  pc_core_ctrl_seq_if #(.C_NUM_CH(N), .C_CNT_WIDTH(32)) if_hs ();
  pc_core_ctrl_seq_if #(.C_NUM_CH(N), .C_CNT_WIDTH(32)) if_ch ();
  pc_core_ctrl_seq_if #(.C_NUM_CH(N), .C_CNT_WIDTH(4))  if_sat ();
  assign if_hs.ap_start     = ap_start;
  assign if_hs.ap_continue  = ap_continue;
  assign if_hs.ch_enable    = ch_enable;
  assign if_hs.ch_done      = ch_done;
  assign if_ch.ap_start     = ap_start;
  assign if_ch.ap_continue  = ap_continue;
  assign if_ch.ch_enable    = ch_enable;
  assign if_ch.ch_done      = ch_done;
  assign if_sat.ap_start    = ap_start;
  assign if_sat.ap_continue = ap_continue;
  assign if_sat.ch_enable   = ch_enable;
  assign if_sat.ch_done     = ch_done;
`ifdef PC_CTRL_WATCHDOG_EN
  assign if_hs.wdog_limit   = wdog_limit;
  assign if_ch.wdog_limit   = wdog_limit;
  assign if_sat.wdog_limit  = wdog_limit[3:0];
`endif
  pc_core_ctrl_seq #(.C_NUM_CH(N), .C_CHAIN_MODE(0), .C_CNT_WIDTH(32)) u_hs (.ap_clk(ap_clk), .areset(areset), .bus(if_hs.slave));
  pc_core_ctrl_seq #(.C_NUM_CH(N), .C_CHAIN_MODE(1), .C_CNT_WIDTH(32)) u_ch (.ap_clk(ap_clk), .areset(areset), .bus(if_ch.slave));
  pc_core_ctrl_seq #(.C_NUM_CH(N), .C_CHAIN_MODE(0), .C_CNT_WIDTH(4))  u_sat (.ap_clk(ap_clk), .areset(areset), .bus(if_sat.slave));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s @%0t got=%0h exp=%0h", tag, $time, got, exp);
    end
  endtask

  // i_*/d_*: expected idle/done of the hs-style and chain instances; st: expected ch_start
  task automatic check_outs(input logic i_hs, input logic d_hs, input logic i_ch, input logic d_ch, input logic [N-1:0] st);
    logic [31:0] cs;
    cs = e_cyc > 32'd15 ? 32'd15 : e_cyc;
    check("hs.idle", 32'(if_hs.ap_idle), 32'(i_hs));
    check("hs.done", 32'(if_hs.ap_done), 32'(d_hs));
    check("hs.ready", 32'(if_hs.ap_ready), 32'(d_hs));
    check("sat.idle", 32'(if_sat.ap_idle), 32'(i_hs));
    check("sat.done", 32'(if_sat.ap_done), 32'(d_hs));
    check("ch.idle", 32'(if_ch.ap_idle), 32'(i_ch));
    check("ch.done", 32'(if_ch.ap_done), 32'(d_ch));
    check("ch.ready", 32'(if_ch.ap_ready), 32'(d_ch));
    check("hs.ch_start", 32'(if_hs.ch_start), 32'(st));
    check("ch.ch_start", 32'(if_ch.ch_start), 32'(st));
    check("sat.ch_start", 32'(if_sat.ch_start), 32'(st));
    check("hs.run_mask", 32'(if_hs.run_mask), 32'(e_mask));
    check("ch.run_mask", 32'(if_ch.run_mask), 32'(e_mask));
    check("hs.run_cycles", if_hs.run_cycles, e_cyc);
    check("ch.run_cycles", if_ch.run_cycles, e_cyc);
    check("sat.run_cycles", 32'(if_sat.run_cycles), cs);
`ifdef PC_CTRL_WATCHDOG_EN
    check("hs.timeout", 32'(if_hs.ap_timeout), 32'(e_to));
    check("ch.timeout", 32'(if_ch.ap_timeout), 32'(e_to));
    check("sat.timeout", 32'(if_sat.ap_timeout), 32'(e_to));
    check("hs.timeout_mask", 32'(if_hs.timeout_mask), 32'(e_tm));
    check("ch.timeout_mask", 32'(if_ch.timeout_mask), 32'(e_tm));
`endif
  endtask

  // One run: dly[i] is the offset from the start cycle of channel i's first done pulse,
  // h the extra cycles ap_continue stays low in DONE, keep holds ap_start high throughout.
  task automatic run(input logic [N-1:0] m, input int lim, input int h, input bit keep);
    int dmax, f;
    bit to;
    dmax = 1;
    for (int i = 0; i < N; i++) if (m[i] && dly[i] > dmax) dmax = dly[i];
    to = lim != 0 && lim < dmax;
    f = to ? lim : dmax;
    ap_start = 1'b0;
    ch_done = '0;
    @(posedge ap_clk); #1;
    check_outs(1'b1, 1'b0, 1'b1, 1'b0, '0);
`ifdef PC_CTRL_WATCHDOG_EN
    wdog_limit = 32'(lim);
`endif
    ch_enable = m;
    ap_start = 1'b1;
    ap_continue = 1'($urandom);
    for (int k = 1; k <= f + 2 + h; k++) begin
      @(posedge ap_clk); #1;
      e_mask = m;
      if (k == f + 1) e_cyc = 32'(f);
`ifdef PC_CTRL_WATCHDOG_EN
      e_to = k >= f + 1 ? 1'(to) : 1'b0;
      e_tm = '0;
      if (k >= f + 1 && to) for (int i = 0; i < N; i++) e_tm[i] = m[i] && dly[i] > lim;
`endif
      check_outs(k >= f + 2, k == f + 1, k >= f + 2 + h, k >= f + 1 && k <= f + 1 + h, k == 1 ? m : '0);
      ch_enable = N'($urandom);
      for (int i = 0; i < N; i++) ch_done[i] = dly[i] == k || (dly[i] < k && $urandom_range(0, 3) == 0);
      ap_start = keep ? 1'b1 : (k >= f + 2 ? 1'b0 : 1'($urandom));
      ap_continue = k <= f ? 1'($urandom) : 1'(k >= f + 1 + h);
    end
    if (keep) repeat (3) begin
      @(posedge ap_clk); #1;
      check_outs(1'b1, 1'b0, 1'b1, 1'b0, '0);
    end
  endtask

  task automatic reset_mid(input int after);
    ap_start = 1'b0;
    ch_done = '0;
`ifdef PC_CTRL_WATCHDOG_EN
    wdog_limit = '0;
`endif
    @(posedge ap_clk); #1;
    ch_enable = '1;
    ap_start = 1'b1;
    repeat (after + 1) begin @(posedge ap_clk); #1; end
    #2 areset = 1'b1;
    #1;
    e_mask = '0;
    e_cyc = '0;
`ifdef PC_CTRL_WATCHDOG_EN
    e_to = 1'b0;
    e_tm = '0;
`endif
    check_outs(1'b1, 1'b0, 1'b1, 1'b0, '0);
    @(posedge ap_clk); #1;
    areset = 1'b0;
    ap_start = 1'b0;
  endtask

  initial begin
    repeat (3) @(posedge ap_clk);
    #1;
    check_outs(1'b1, 1'b0, 1'b1, 1'b0, '0);
    areset = 1'b0;
    dly = '{4, 9, 2, 30};
    run(4'b0011, 0, 0, 1'b0);
    dly = '{1, 3, 1, 1};
    run(4'b0010, 0, 0, 1'b0);
    run(4'b0000, 0, 0, 1'b0);
    dly = '{6, 2, 3, 5};
    run(4'b0101, 0, 5, 1'b0);
    run(4'b1111, 0, 0, 1'b1);
    run(4'b1000, 0, 2, 1'b0);
    reset_mid(3);
    dly = '{2, 5, 7, 1};
    run(4'b0110, 0, 0, 1'b0);
`ifdef PC_CTRL_WATCHDOG_EN
    dly = '{2, 20, 1, 1};
    run(4'b0011, 8, 0, 1'b0);
    dly = '{3, 8, 1, 1};
    run(4'b0011, 8, 0, 1'b0);
    run(4'b0001, 0, 0, 1'b0);
`endif
    dly = '{20, 1, 1, 1};
    run(4'b0001, 0, 0, 1'b0);
    for (int r = 0; r < 40; r++) begin
      int lim;
      for (int i = 0; i < N; i++) dly[i] = int'($urandom_range(1, 24));
      lim = 0;
`ifdef PC_CTRL_WATCHDOG_EN
      if ($urandom_range(0, 1) == 1) lim = int'($urandom_range(1, 15));
`endif
      run(N'($urandom), lim, $urandom_range(0, 1) == 1 ? 0 : int'($urandom_range(1, 4)), $urandom_range(0, 7) == 0);
      if ($urandom_range(0, 9) == 0) reset_mid(int'($urandom_range(0, 5)));
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
